// File: rtl/peak_report_reader.sv
// rtl/peak_report_reader.sv - peak-report capture FIFO with per-frame peak statistics
module peak_report_reader #(
    parameter int VALUE_WIDTH = 12,
    parameter int INDEX_WIDTH = 12,
    parameter int DEPTH       = 16,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [31:0]            p_i_s,
    input  logic                   p_valid,
    input  logic                   last_out,
    input  logic                   rd_ready,
    output logic                   rd_valid,
    output logic [VALUE_WIDTH-1:0] rd_peak,
    output logic                   rd_side,
    output logic [INDEX_WIDTH-1:0] rd_index,
    output logic                   rd_eof,
    output logic                   rd_marker,
    output logic                   frame_done,
    output logic [CNT_WIDTH-1:0]   frame_peaks,
    output logic [VALUE_WIDTH-1:0] frame_max_peak,
    output logic [INDEX_WIDTH-1:0] frame_max_index,
    output logic [CNT_WIDTH-1:0]   frame_count,
    output logic                   overflow,
    input  logic                   clr_overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = VALUE_WIDTH + 1 + INDEX_WIDTH + 2;

    logic [EW-1:0]          mem [DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [AW:0]            count;
    logic [VALUE_WIDTH-1:0] in_peak;
    logic                   in_side;
    logic [INDEX_WIDTH-1:0] in_index;
    logic [EW-1:0]          entry;
    logic [EW-1:0]          head;
    logic                   push;
    logic                   pop;
    logic                   full;
    logic                   wr_en;
    logic                   drop;

    assign in_peak  = p_i_s[31 -: VALUE_WIDTH];
    assign in_side  = p_i_s[31-VALUE_WIDTH];
    assign in_index = p_i_s[INDEX_WIDTH-1:0];

    assign push  = p_valid | last_out;
    assign full  = (count == (AW+1)'(DEPTH));
    assign pop   = rd_valid & rd_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign wr_en = push & (~full | pop);
    assign drop  = push & full & ~pop;

    assign entry = p_valid ? {in_peak, in_side, in_index, last_out, 1'b0}
                           : {{(VALUE_WIDTH+1+INDEX_WIDTH){1'b0}}, 2'b11};

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= entry;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign head      = mem[rd_ptr];
    assign rd_valid  = (count != '0);
    assign rd_peak   = head[EW-1 -: VALUE_WIDTH];
    assign rd_side   = head[INDEX_WIDTH+2];
    assign rd_index  = head[INDEX_WIDTH+1:2];
    assign rd_eof    = head[1];
    assign rd_marker = head[0];

    logic [CNT_WIDTH-1:0]   run_cnt;
    logic [VALUE_WIDTH-1:0] run_max;
    logic [INDEX_WIDTH-1:0] run_idx;
    logic [CNT_WIDTH-1:0]   cnt_next;
    logic [VALUE_WIDTH-1:0] max_next;
    logic [INDEX_WIDTH-1:0] idx_next;

    // Strict compare keeps the earliest index on equal peaks.
    always_comb begin
        cnt_next = run_cnt;
        max_next = run_max;
        idx_next = run_idx;
        if (p_valid) begin
            if (run_cnt != '1)
                cnt_next = run_cnt + CNT_WIDTH'(1);
            if (in_peak > run_max) begin
                max_next = in_peak;
                idx_next = in_index;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            run_cnt         <= '0;
            run_max         <= '0;
            run_idx         <= '0;
            frame_done      <= 1'b0;
            frame_peaks     <= '0;
            frame_max_peak  <= '0;
            frame_max_index <= '0;
            frame_count     <= '0;
        end else begin
            frame_done <= last_out;
            if (last_out) begin
                frame_peaks     <= cnt_next;
                frame_max_peak  <= max_next;
                frame_max_index <= idx_next;
                frame_count     <= frame_count + CNT_WIDTH'(1);
                run_cnt         <= '0;
                run_max         <= '0;
                run_idx         <= '0;
            end else begin
                run_cnt <= cnt_next;
                run_max <= max_next;
                run_idx <= idx_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            overflow <= 1'b0;
        else if (drop)
            overflow <= 1'b1;
        else if (clr_overflow)
            overflow <= 1'b0;
    end
endmodule

// File: tb/tb_peak_report_reader.sv
// tb/tb_peak_report_reader.sv - randomized and directed bench for peak_report_reader
module tb_peak_report_reader;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] p_i_s;
    logic        p_valid, last_out, rd_ready, clr_overflow;
    logic        rd_valid, rd_side, rd_eof, rd_marker, frame_done, overflow;
    logic [11:0] rd_peak, rd_index, frame_max_peak, frame_max_index;
    logic [7:0]  frame_peaks, frame_count;

    peak_report_reader #(.VALUE_WIDTH(12), .INDEX_WIDTH(12), .DEPTH(16), .CNT_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .p_i_s(p_i_s), .p_valid(p_valid), .last_out(last_out),
        .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_peak(rd_peak), .rd_side(rd_side),
        .rd_index(rd_index), .rd_eof(rd_eof), .rd_marker(rd_marker), .frame_done(frame_done),
        .frame_peaks(frame_peaks), .frame_max_peak(frame_max_peak),
        .frame_max_index(frame_max_index), .frame_count(frame_count), .overflow(overflow),
        .clr_overflow(clr_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned peak;
        int unsigned side;
        int unsigned idx;
        int unsigned eof;
        int unsigned marker;
    } ent_t;

    ent_t        q[$];
    int unsigned m_cnt, m_max, m_idx;
    int unsigned f_peaks, f_max, f_idx, f_count, f_done, m_ovf;
    int          checks = 0;
    int          failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input int unsigned peak, input int unsigned side,
                                       input int unsigned idx);
        logic [31:0] w;
        w = $urandom;
        w[31:20] = peak[11:0];
        w[19]    = side[0];
        w[11:0]  = idx[11:0];
        return w;
    endfunction

    // Reference behaviour: bounded queue of entries plus per-frame running stats.
    task automatic model_step();
        ent_t e;
        bit   pop, push;
        int unsigned pk, ix;
        if (reset) begin
            q.delete();
            {m_cnt, m_max, m_idx, f_peaks, f_max, f_idx, f_count, f_done, m_ovf} = '0;
            return;
        end
        pk   = int'(p_i_s[31:20]);
        ix   = int'(p_i_s[11:0]);
        pop  = (q.size() > 0) && rd_ready;
        push = p_valid || last_out;
        if (push && q.size() == 16 && !pop) m_ovf = 1;
        else if (clr_overflow) m_ovf = 0;
        if (pop) void'(q.pop_front());
        if (push && q.size() < 16) begin
            if (p_valid) begin
                e.peak = pk; e.side = p_i_s[19]; e.idx = ix; e.eof = last_out; e.marker = 0;
            end else begin
                e.peak = 0; e.side = 0; e.idx = 0; e.eof = 1; e.marker = 1;
            end
            q.push_back(e);
        end
        if (p_valid) begin
            m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
            if (pk > m_max) begin m_max = pk; m_idx = ix; end
        end
        f_done = last_out;
        if (last_out) begin
            f_peaks = m_cnt; f_max = m_max; f_idx = m_idx;
            f_count = (f_count + 1) % 256;
            m_cnt = 0; m_max = 0; m_idx = 0;
        end
    endtask

    task automatic compare_all();
        check("rd_valid", rd_valid, q.size() != 0);
        if (q.size() != 0) begin
            check("rd_peak", rd_peak, q[0].peak);
            check("rd_side", rd_side, q[0].side);
            check("rd_index", rd_index, q[0].idx);
            check("rd_eof", rd_eof, q[0].eof);
            check("rd_marker", rd_marker, q[0].marker);
        end
        check("frame_done", frame_done, f_done);
        check("frame_peaks", frame_peaks, f_peaks);
        check("frame_max_peak", frame_max_peak, f_max);
        check("frame_max_index", frame_max_index, f_idx);
        check("frame_count", frame_count, f_count);
        check("overflow", overflow, m_ovf);
    endtask

    task automatic tick(input logic pv, input logic [31:0] w, input logic lo, input logic rr,
                        input logic co, input logic rs);
        p_valid = pv; p_i_s = w; last_out = lo; rd_ready = rr; clr_overflow = co; reset = rs;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        {p_valid, last_out, rd_ready, clr_overflow} = '0;
        p_i_s = '0;
        reset = 1'b1;
        @(negedge clk);
        tick(0, 0, 0, 0, 0, 1);
        tick(0, 0, 0, 0, 0, 1);
        check("reset_rd_valid", rd_valid, 0);
        check("reset_frame_count", frame_count, 0);

        tick(1, mk(12'h034, 0, 1), 0, 0, 0, 0);
        check("first_push_visible", rd_valid, 1);
        tick(1, mk(12'hA34, 1, 2), 0, 0, 0, 0);
        tick(1, mk(12'h137, 0, 3), 0, 0, 0, 0);
        repeat (4) tick(0, 0, 0, 1, 0, 0);
        check("drained_empty", rd_valid, 0);
        tick(0, 0, 0, 0, 0, 1);

        tick(1, mk(12'h514, 0, 8), 0, 0, 0, 0);
        tick(1, mk(12'h0C3, 1, 9), 0, 0, 0, 0);
        tick(1, mk(12'h0C3, 0, 10), 0, 0, 0, 0);
        tick(1, mk(12'hB37, 1, 20), 1, 0, 0, 0);
        check("f1_done", frame_done, 1);
        check("f1_peaks", frame_peaks, 4);
        check("f1_max", frame_max_peak, 12'hB37);
        check("f1_idx", frame_max_index, 20);
        check("f1_count", frame_count, 1);
        repeat (3) tick(0, 0, 0, 1, 0, 0);
        check("f1_last_eof", rd_eof, 1);
        check("f1_last_marker", rd_marker, 0);
        tick(0, 0, 0, 1, 0, 0);

        tick(1, mk(12'h884, 0, 5), 0, 0, 0, 0);
        tick(1, mk(12'h884, 1, 9), 0, 0, 0, 0);
        tick(0, mk(12'hFFF, 1, 7), 1, 0, 0, 0);
        check("tie_idx", frame_max_index, 5);
        check("tie_peaks", frame_peaks, 2);
        repeat (2) tick(0, 0, 0, 1, 0, 0);
        check("marker_flag", rd_marker, 1);
        check("marker_peak", rd_peak, 0);
        tick(0, 0, 0, 1, 0, 0);

        for (int i = 0; i < 17; i++) tick(1, mk(i * 7, i % 2, i), 0, 0, 0, 0);
        check("ovf_set", overflow, 1);
        for (int i = 0; i < 16; i++) begin
            check("ovf_drain_idx", rd_index, i);
            tick(0, 0, 0, 1, 0, 0);
        end
        check("ovf_drain_empty", rd_valid, 0);
        tick(0, 0, 0, 0, 1, 0);
        check("ovf_clear", overflow, 0);

        for (int i = 0; i < 16; i++) tick(1, mk(i, 0, 40 + i), 0, 0, 0, 0);
        tick(1, mk(12'h777, 1, 99), 0, 1, 0, 0);
        check("full_pushpop_ovf", overflow, 0);
        check("full_pushpop_occ", q.size(), 16);
        for (int i = 0; i < 15; i++) tick(0, 0, 0, 1, 0, 0);
        check("full_pushpop_tail", rd_index, 99);
        tick(0, 0, 0, 1, 0, 0);

        for (int i = 0; i < 5; i++) tick(1, mk(i + 1, 0, i), 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 1);
        check("midreset_valid", rd_valid, 0);
        tick(1, mk(12'h010, 0, 1), 0, 0, 0, 0);
        tick(1, mk(12'h020, 0, 2), 1, 0, 0, 0);
        check("post_reset_peaks", frame_peaks, 2);
        check("post_reset_count", frame_count, 1);

        for (int i = 0; i < 300; i++) tick(1, mk($urandom_range(0, 4095), 0, i), 0, 1, 0, 0);
        tick(0, 0, 1, 1, 0, 0);
        check("sat_peaks", frame_peaks, 255);

        for (int i = 0; i < 3000; i++) begin
            int unsigned pk;
            pk = ($urandom_range(0, 3) == 0) ? 12'h800 : $urandom_range(0, 4095);
            tick($urandom_range(0, 1), mk(pk, $urandom_range(0, 1), $urandom_range(0, 4095)),
                 $urandom_range(0, 5) == 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 19) == 0, $urandom_range(0, 299) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/peak_report_reader.md
# peak_report_reader

Receive-side consumer for the packed peak-report stream produced by the peak-doubles stage. Captures each `p_i_s` word, decodes its fields, and stores it with frame-boundary markers in a first-word-fall-through FIFO that downstream logic (host register bank or DMA packer) drains with a ready/valid handshake. Also computes per-frame statistics (peak count and strongest peak) and tracks FIFO overflow.

## Interface

Parameters:
- `VALUE_WIDTH`, 12, width of the peak magnitude field (matches `constants.vh`).
- `INDEX_WIDTH`, 12, width of the index field (matches `constants.vh`).
- `DEPTH`, 16, number of FIFO entries; must be a power of 2, at least 2.
- `CNT_WIDTH`, 8, width of the per-frame peak counter and the frame counter.

Ports:
- `clk`  in  1  single clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `p_i_s`  in  32  packed report. Peak is `[31:32-VALUE_WIDTH]`, side is `[31-VALUE_WIDTH]`, index is `[INDEX_WIDTH-1:0]`. Remaining bits are ignored.
- `p_valid`  in  1  `p_i_s` holds a report this cycle.
- `last_out`  in  1  end of frame. It may coincide with `p_valid` or arrive alone.
- `rd_ready`  in  1  consumer accepts the head entry.
- `rd_valid`  out  1  head entry is present.
- `rd_peak`  out  VALUE_WIDTH  head entry peak.
- `rd_side`  out  1  head entry side bit.
- `rd_index`  out  INDEX_WIDTH  head entry index.
- `rd_eof`  out  1  head entry closes a frame.
- `rd_marker`  out  1  head entry is a data-less end-of-frame marker.
- `frame_done`  out  1  one-cycle pulse when frame statistics update.
- `frame_peaks`  out  CNT_WIDTH  reports in the last completed frame; saturates.
- `frame_max_peak`  out  VALUE_WIDTH  largest peak in the last completed frame.
- `frame_max_index`  out  INDEX_WIDTH  index of that peak.
- `frame_count`  out  CNT_WIDTH  completed frames since reset; wraps.
- `overflow`  out  1  sticky; a write was dropped because the FIFO was full.
- `clr_overflow`  in  1  clears `overflow`.

## Operation

- Push event: a cycle with `p_valid` or `last_out`.
  - `p_valid=1`: the decoded fields are written. `eof` = `last_out`, `marker` = 0.
  - `last_out=1` and `p_valid=0`: a marker entry is written with peak, side and index all 0, `eof` = 1, `marker` = 1.
- Pop: `rd_valid && rd_ready`. `rd_*` always shows the head entry; `rd_*` fields are don't-care when `rd_valid` = 0.
- Full with push, no pop: the entry is dropped and `overflow` is set on the next edge. Frame statistics still update; a dropped entry never corrupts stored entries.
- Full with push and pop in the same cycle: both succeed and occupancy is unchanged.
- Empty with push and `rd_ready` in the same cycle: push only, no bypass.
- Pointers are `log2(DEPTH)` bits and wrap modulo `DEPTH`. Occupancy is a `log2(DEPTH)+1`-bit counter.
- Running statistics:
  - Each `p_valid` increments the running count, saturating at `2^CNT_WIDTH-1`.
  - The running maximum is replaced only when a peak is strictly greater, so on ties the earliest index wins.
  - On a `last_out` cycle, the word of that same cycle (if any) is included. The completed values are then loaded into `frame_*` and the running state is cleared for the next frame.
  - An empty frame (marker only) yields `frame_peaks=0`, `frame_max_peak=0`, `frame_max_index=0`.
- `overflow`: set has priority over `clr_overflow` in the same cycle.
- Reset, including mid-operation:
  - FIFO is emptied and pointers go to 0.
  - All outputs go to 0: `rd_valid`, `frame_done`, `frame_*`, `frame_count`, `overflow`.
  - Running statistics are cleared. A partial frame in progress is discarded.

## Timing

- Push at edge N → `rd_valid` high after edge N; the entry is visible in cycle N+1.
- Pop at edge N → the next entry, or `rd_valid=0`, after edge N.
- `last_out` sampled at edge N → `frame_*` registered and `frame_done` high in cycle N+1, for exactly one cycle. `frame_count` increments at that same edge.
- Back-to-back `last_out` is legal; each one produces its own `frame_done` pulse and entry.
- No combinational path from `rd_ready` to `rd_valid`.

## Test plan

- Reset check → all outputs 0. Then push 3 reports (peaks 0x034, 0xA34, 0x137; indices 1, 2, 3; side 0, 1, 0) → `rd_valid` rises 1 cycle after the first push. Hold `rd_ready=1` → the three reports appear in order, and `rd_valid` drops after the third pop.
- Frame of peaks 0x514, 0xC3, 0xC3, 0xB37 (indices 8, 9, 10, 20), with `last_out` on the 0xB37 word → one cycle later `frame_done=1`, `frame_peaks=4`, `frame_max_peak=0xB37`, `frame_max_index=20`, `frame_count=1`; the last entry has `rd_eof=1`, `rd_marker=0`.
- Tie case: peaks 0x884 at index 5 then 0x884 at index 9, then `last_out` alone → `frame_max_index=5`, `frame_peaks=2`, and a marker entry (`rd_eof=1`, `rd_marker=1`, peak 0).
- With `rd_ready=0`, push 17 reports at `DEPTH=16` → `overflow=1`; draining yields exactly the first 16 entries. Then pulse `clr_overflow` → `overflow=0`.
- FIFO full, with push and `rd_ready` in the same cycle → occupancy stays 16, `overflow` stays 0, and the new entry appears last.
- Assert `reset` mid-frame with 5 entries stored → `rd_valid=0` next cycle. A following frame of 2 reports then gives `frame_peaks=2` and `frame_count=1`.
